// File: rtl/top_output_controller.sv
// Register-mapped output pin driver with a one-shot pulse engine.
// A pulse inverts selected pins for a programmable number of clk cycles.
module top_output_controller #(
    parameter int NUM_OUTPUTS = 12,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [1:0]             register_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   done,
    output logic                   irq,
    output logic [NUM_OUTPUTS-1:0] out_pins
);

    // state | meaning
    // IDLE  | no pulse active, mask_reg is zero
    // PULSE | masked pins inverted, cnt counting down to terminal count 1
    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_DATA  = 2'd1;
    localparam logic [1:0] ADDR_PULSE = 2'd2;
    localparam logic [1:0] ADDR_PLEN  = 2'd3;

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            plen_q, plen_d;
    logic [NUM_OUTPUTS-1:0] data_q, data_d;
    logic [NUM_OUTPUTS-1:0] mask_q, mask_d;
    logic [NUM_OUTPUTS-1:0] pins_q, pins_d;
    logic                   out_en_q, out_en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   irq_pend_q, irq_pend_d;
    logic                   done_q, done_d;

    logic                   busy;
    logic                   mask_nz;
    logic                   unused_wr_bits;

    assign busy           = (state_q == PULSE);
    assign mask_nz        = |wr_data[NUM_OUTPUTS-1:0];
    assign unused_wr_bits = ^wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            plen_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            pins_q     <= '0;
            out_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            plen_q     <= plen_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            pins_q     <= pins_d;
            out_en_q   <= out_en_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        plen_d     = plen_q;
        data_d     = data_q;
        mask_d     = mask_q;
        out_en_d   = out_en_q;
        irq_en_d   = irq_en_q;
        irq_pend_d = 1'b0;
        done_d     = we;
        pins_d     = out_en_q ? (data_q ^ mask_q) : '0;

        if (we) begin
            case (register_addr)
                ADDR_CTRL: begin
                    out_en_d = wr_data[0];
                    irq_en_d = wr_data[1];
                end
                ADDR_DATA:  data_d = wr_data[NUM_OUTPUTS-1:0];
                ADDR_PLEN:  plen_d = wr_data[15:0];
                ADDR_PULSE: begin
                    // Writes while a pulse runs are acknowledged but dropped.
                    if (state_q == IDLE && mask_nz && plen_q != 16'd0) begin
                        state_d = PULSE;
                        mask_d  = wr_data[NUM_OUTPUTS-1:0];
                        cnt_d   = plen_q;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            PULSE: begin
                if (cnt_q == 16'd1) begin
                    state_d    = IDLE;
                    mask_d     = '0;
                    cnt_d      = 16'd0;
                    irq_pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (register_addr)
            ADDR_CTRL: begin
                rd_data[31] = busy;
                rd_data[1]  = irq_en_q;
                rd_data[0]  = out_en_q;
            end
            ADDR_DATA:  rd_data[NUM_OUTPUTS-1:0] = data_q;
            ADDR_PULSE: rd_data[NUM_OUTPUTS-1:0] = mask_q;
            ADDR_PLEN:  rd_data[15:0]            = plen_q;
            default: ;
        endcase
    end

    assign out_pins = pins_q;
    assign done     = done_q;
    assign irq      = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_top_output_controller.sv
// Scoreboard bench for top_output_controller: stimulus queues the expected
// post-edge outputs, a monitor pops and compares them.
module tb_top_output_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  register_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        done;
    logic        irq;
    logic [11:0] out_pins;

    int checks = 0;
    int errors = 0;
    int tag    = 0;

    typedef struct {
        int          id;
        logic [11:0] pins;
        logic        irq;
        logic        done;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    top_output_controller #(.NUM_OUTPUTS(12), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .we            (we),
        .register_addr (register_addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .done          (done),
        .irq           (irq),
        .out_pins      (out_pins)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, id, act, req);
        end
    endtask

    task automatic push_exp(input logic [11:0] ep, input logic ei, input logic ed,
                            input logic cr, input logic [31:0] er);
        exp_t e;
        tag++;
        e.id = tag; e.pins = ep; e.irq = ei; e.done = ed; e.chk_rd = cr; e.rd = er;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive, take the edge, queue what must be seen after it.
    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [11:0] ep, input logic ei, input logic ed,
                        input logic [31:0] er);
        we = w; register_addr = a; wr_data = d;
        @(posedge clk);
        push_exp(ep, ei, ed, 1'b1, er);
        @(negedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("out_pins", e.id, {20'd0, out_pins}, {20'd0, e.pins});
                cmp("irq",      e.id, {31'd0, irq},      {31'd0, e.irq});
                cmp("done",     e.id, {31'd0, done},     {31'd0, e.done});
                if (e.chk_rd) cmp("rd_data", e.id, rd_data, e.rd);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; we = 1'b0; register_addr = 2'd0; wr_data = '0;
        // reset state
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h0);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h0);
        rst = 1'b0;

        // basic data drive with one-cycle latency
        step(1, 0, 32'h1,        12'h000, 0, 1, 32'h1);
        step(1, 1, 32'hA5,       12'h000, 0, 1, 32'hA5);
        step(0, 1, 32'h0,        12'h0A5, 0, 0, 32'hA5);
        step(0, 1, 32'h0,        12'h0A5, 0, 0, 32'hA5);

        // 3-cycle pulse on 0x00F with irq enabled; upper DATA bits ignored
        step(1, 3, 32'h3,        12'h0A5, 0, 1, 32'h3);
        step(1, 1, 32'hFFFF_F000,12'h0A5, 0, 1, 32'h0);
        step(1, 0, 32'h3,        12'h000, 0, 1, 32'h3);
        step(1, 2, 32'h00F,      12'h000, 0, 1, 32'h00F);
        step(0, 0, 32'h0,        12'h00F, 0, 0, 32'h8000_0003);
        step(0, 0, 32'h0,        12'h00F, 0, 0, 32'h8000_0003);
        step(0, 0, 32'h0,        12'h00F, 1, 0, 32'h3);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h3);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h3);

        // PULSE write during an active pulse is dropped
        step(1, 2, 32'h00F,      12'h000, 0, 1, 32'h00F);
        step(1, 2, 32'h0F0,      12'h00F, 0, 1, 32'h00F);
        step(0, 2, 32'h0,        12'h00F, 0, 0, 32'h00F);
        step(0, 2, 32'h0,        12'h00F, 1, 0, 32'h000);
        step(0, 2, 32'h0,        12'h000, 0, 0, 32'h000);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h3);

        // zero plen and zero mask never start a pulse
        step(1, 1, 32'h3C,       12'h000, 0, 1, 32'h3C);
        step(1, 3, 32'h0,        12'h03C, 0, 1, 32'h0);
        step(1, 2, 32'h001,      12'h03C, 0, 1, 32'h000);
        step(0, 0, 32'h0,        12'h03C, 0, 0, 32'h3);
        step(1, 3, 32'h4,        12'h03C, 0, 1, 32'h4);
        step(1, 2, 32'h000,      12'h03C, 0, 1, 32'h000);
        step(0, 0, 32'h0,        12'h03C, 0, 0, 32'h3);
        step(0, 0, 32'h0,        12'h03C, 0, 0, 32'h3);

        // irq disabled, 5-cycle pulse on pin 11
        step(1, 0, 32'h1,        12'h03C, 0, 1, 32'h1);
        step(1, 1, 32'h0,        12'h03C, 0, 1, 32'h0);
        step(1, 3, 32'h5,        12'h000, 0, 1, 32'h5);
        step(1, 2, 32'h800,      12'h000, 0, 1, 32'h800);
        for (int i = 0; i < 4; i++)
            step(0, 0, 32'h0,    12'h800, 0, 0, 32'h8000_0001);
        step(0, 0, 32'h0,        12'h800, 0, 0, 32'h1);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h1);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h1);

        // DATA write and out_en drop mid-pulse; count keeps running
        step(1, 0, 32'h3,        12'h000, 0, 1, 32'h3);
        step(1, 2, 32'h00F,      12'h000, 0, 1, 32'h00F);
        step(1, 1, 32'h100,      12'h00F, 0, 1, 32'h100);
        step(1, 0, 32'h2,        12'h10F, 0, 1, 32'h8000_0002);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h8000_0002);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h8000_0002);
        step(0, 0, 32'h0,        12'h000, 1, 0, 32'h2);
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h2);
        step(1, 0, 32'hFFFF_FFF1,12'h000, 0, 1, 32'h1);
        step(0, 1, 32'h0,        12'h100, 0, 0, 32'h100);

        // reset in the middle of a 10-cycle pulse
        step(1, 0, 32'h3,        12'h100, 0, 1, 32'h3);
        step(1, 1, 32'h0,        12'h100, 0, 1, 32'h0);
        step(1, 3, 32'hA,        12'h000, 0, 1, 32'hA);
        step(1, 2, 32'h00F,      12'h000, 0, 1, 32'h00F);
        step(0, 0, 32'h0,        12'h00F, 0, 0, 32'h8000_0003);
        step(0, 0, 32'h0,        12'h00F, 0, 0, 32'h8000_0003);
        rst = 1'b1;
        #1;
        push_exp(12'h000, 0, 0, 1'b1, 32'h0);
        -> sample_ev;
        #1;
        step(0, 0, 32'h0,        12'h000, 0, 0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            step(0, 0, 32'h0,    12'h000, 0, 0, 32'h0);
        step(0, 1, 32'h0,        12'h000, 0, 0, 32'h0);
        step(0, 3, 32'h0,        12'h000, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        cmp("scoreboard_drain", tag, exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
